// File: rtl/sha256_w_sched_seq_if.sv
// Load/stream bundle for the SHA-256 message-schedule generator.
// The master side is the schedule source; the slave side loads blocks and consumes words.
interface sha256_w_sched_seq_if;
  logic         start;
  logic [511:0] block_in;
  logic         busy;
  logic         w_valid;
  logic         w_ready;
  logic [31:0]  w_out;
  logic [5:0]   w_index;
  logic         done;

  modport master (
    input  start, block_in, w_ready,
    output busy, w_valid, w_out, w_index, done
  );

  modport slave (
    output start, block_in, w_ready,
    input  busy, w_valid, w_out, w_index, done
  );
endinterface

// File: rtl/sha256_w_sched_seq.sv
// Sequential SHA-256 message schedule: loads a 512-bit block and streams W[0..NUM_WORDS-1]
// from a 16-word sliding window, one word per valid/ready handshake.
module sha256_w_sched_seq #(
  parameter int NUM_WORDS = 64
) (
  input  logic                  CLK,
  input  logic                  RST,
  sha256_w_sched_seq_if.master  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [5:0] LAST_T = 6'(NUM_WORDS - 1);

  state_t      state;
  logic [31:0] win [16];
  logic [5:0]  t;
  logic        busy_q;
  logic        valid_q;
  logic        done_q;
  logic [31:0] next_word;
  logic        handshake;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  // win[0] is W[t]; the new tail word is W[t+16] expressed relative to that window
  assign next_word = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
  assign handshake = valid_q & bus.w_ready;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state   <= IDLE;
      for (int i = 0; i < 16; i++) win[i] <= '0;
      t       <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            for (int i = 0; i < 16; i++) win[i] <= bus.block_in[511 - 32*i -: 32];
            t       <= '0;
            state   <= RUN;
            busy_q  <= 1'b1;
            valid_q <= 1'b1;
          end
        end
        RUN: begin
          if (handshake) begin
            for (int i = 0; i < 15; i++) win[i] <= win[i+1];
            win[15] <= next_word;
            // t saturates at the last index so w_index never runs past the block
            if (t == LAST_T) begin
              state   <= DONE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              t <= t + 6'd1;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.w_valid = valid_q;
  assign bus.done    = done_q;
  assign bus.w_out   = win[0];
  assign bus.w_index = t;

endmodule

// File: tb/tb_sha256_w_sched_seq.sv
// Bench for sha256_w_sched_seq: a 64-word and a 17-word instance checked every cycle
// against a schedule model built from the textbook W[t] recurrence, plus directed scenarios.
module tb_sha256_w_sched_seq;

  typedef logic [63:0][31:0] sched_t;
  typedef enum {P_IDLE, P_STREAM, P_PULSE} mphase_t;

  localparam logic [511:0] ABC = {32'h61626380, {14{32'h00000000}}, 32'h00000018};

  logic CLK;
  logic RST;

  logic         s_start [2];
  logic [511:0] s_block [2];
  logic         s_ready [2];

  logic         d_valid [2];
  logic         d_busy  [2];
  logic         d_done  [2];
  logic [31:0]  d_out   [2];
  logic [5:0]   d_idx   [2];

  mphase_t m_phase [2];
  int      m_idx   [2];
  sched_t  m_w     [2];
  bit      m_clean [2];
  int      m_loads [2];
  int      m_dones [2];
  int      m_num   [2];

  int dut_dones [2];
  int checks;
  int failures;
  bit check_en;

  sha256_w_sched_seq_if bus0 ();
  sha256_w_sched_seq_if bus1 ();

  assign bus0.start    = s_start[0];
  assign bus0.block_in = s_block[0];
  assign bus0.w_ready  = s_ready[0];
  assign bus1.start    = s_start[1];
  assign bus1.block_in = s_block[1];
  assign bus1.w_ready  = s_ready[1];

  assign d_valid[0] = bus0.w_valid;
  assign d_busy[0]  = bus0.busy;
  assign d_done[0]  = bus0.done;
  assign d_out[0]   = bus0.w_out;
  assign d_idx[0]   = bus0.w_index;
  assign d_valid[1] = bus1.w_valid;
  assign d_busy[1]  = bus1.busy;
  assign d_done[1]  = bus1.done;
  assign d_out[1]   = bus1.w_out;
  assign d_idx[1]   = bus1.w_index;

  sha256_w_sched_seq #(.NUM_WORDS(64)) dut0 (.CLK(CLK), .RST(RST), .bus(bus0));
  sha256_w_sched_seq #(.NUM_WORDS(17)) dut1 (.CLK(CLK), .RST(RST), .bus(bus1));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic sched_t make_sched(input logic [511:0] b);
    sched_t w;
    for (int k = 0; k < 16; k++) w[k] = b[511 - 32*k -: 32];
    for (int k = 16; k < 64; k++)
      w[k] = small_sigma1(w[k-2]) + w[k-7] + small_sigma0(w[k-15]) + w[k-16];
    return w;
  endfunction

  task automatic checkOutput(input int inst, input string name,
                             input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL inst%0d %s actual=0x%08h expected=0x%08h at %0t",
               inst, name, act, exp, $time);
    end
  endtask

  task automatic report_timeout(input int inst, input string name);
    checks++;
    failures++;
    $display("[TB] FAIL inst%0d timeout %s at %0t", inst, name, $time);
  endtask

  task automatic applyStimulus(input int inst, input logic st,
                               input logic [511:0] blk, input logic rdy);
    s_start[inst] = st;
    s_block[inst] = blk;
    s_ready[inst] = rdy;
  endtask

  task automatic wait_index(input int inst, input int target, input int bound);
    bit found = 1'b0;
    for (int k = 0; k < bound && !found; k++) begin
      if (d_valid[inst] === 1'b1 && d_idx[inst] == 6'(target)) found = 1'b1;
      else @(negedge CLK);
    end
    if (!found) report_timeout(inst, "wait_index");
  endtask

  task automatic wait_idle(input int inst, input int bound);
    bit found = 1'b0;
    for (int k = 0; k < bound && !found; k++) begin
      if (m_phase[inst] == P_IDLE) found = 1'b1;
      else @(negedge CLK);
    end
    if (!found) report_timeout(inst, "wait_idle");
  endtask

  task automatic load_block(input int inst, input logic [511:0] blk);
    applyStimulus(inst, 1'b1, blk, 1'b1);
    @(negedge CLK);
    applyStimulus(inst, 1'b0, blk, 1'b1);
  endtask

  task automatic random_run(input int inst, input int n_blocks, input int limit);
    int base = m_loads[inst];
    bit finished = 1'b0;
    logic [511:0] blk;
    logic st;
    for (int cyc = 0; cyc < limit && !finished; cyc++) begin
      @(negedge CLK);
      if (m_loads[inst] - base >= n_blocks && m_phase[inst] == P_IDLE) begin
        finished = 1'b1;
      end else begin
        for (int k = 0; k < 16; k++) blk[k*32 +: 32] = $urandom();
        st = (m_loads[inst] - base < n_blocks) &&
             ($urandom_range(0, 7) == 0 ||
              (m_phase[inst] == P_IDLE && $urandom_range(0, 1) == 0));
        applyStimulus(inst, st, blk, $urandom_range(0, 3) != 0);
      end
    end
    applyStimulus(inst, 1'b0, '0, 1'b0);
    if (!finished) report_timeout(inst, "random_run");
  endtask

  // Reference model: which word of the loaded block's schedule is being offered, if any
  always @(posedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      if (!RST) begin
        m_phase[i] <= P_IDLE;
        m_idx[i]   <= 0;
        m_clean[i] <= 1'b1;
      end else begin
        case (m_phase[i])
          P_IDLE: if (s_start[i]) begin
            m_w[i]     <= make_sched(s_block[i]);
            m_idx[i]   <= 0;
            m_phase[i] <= P_STREAM;
            m_clean[i] <= 1'b0;
            m_loads[i] <= m_loads[i] + 1;
          end
          P_STREAM: if (s_ready[i]) begin
            if (m_idx[i] == m_num[i] - 1) begin
              m_phase[i] <= P_PULSE;
              m_dones[i] <= m_dones[i] + 1;
            end else begin
              m_idx[i] <= m_idx[i] + 1;
            end
          end
          default: m_phase[i] <= P_IDLE;
        endcase
      end
    end
  end

  always @(negedge CLK) begin
    if (check_en) begin
      for (int i = 0; i < 2; i++) begin
        checkOutput(i, "w_valid", d_valid[i], m_phase[i] == P_STREAM);
        checkOutput(i, "busy", d_busy[i], m_phase[i] != P_IDLE);
        checkOutput(i, "done", d_done[i], m_phase[i] == P_PULSE);
        if (m_phase[i] == P_STREAM) begin
          checkOutput(i, "w_index", d_idx[i], m_idx[i]);
          checkOutput(i, "w_out", d_out[i], m_w[i][m_idx[i]]);
        end
        if (m_clean[i]) begin
          checkOutput(i, "reset w_out", d_out[i], 32'h0);
          checkOutput(i, "reset w_index", d_idx[i], 32'h0);
        end
        if (d_done[i] === 1'b1) dut_dones[i]++;
      end
    end
  end

  initial begin
    #2_000_000;
    failures++;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    sched_t abc_s;
    sched_t other_s;
    logic [511:0] other;
    logic [31:0] last_out;
    int cnt;
    int done_base [2];

    checks = 0;
    failures = 0;
    check_en = 1'b0;
    m_num[0] = 64;
    m_num[1] = 17;
    for (int i = 0; i < 2; i++) begin
      m_loads[i] = 0;
      m_dones[i] = 0;
      dut_dones[i] = 0;
      applyStimulus(i, 1'b0, '0, 1'b0);
    end
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_en = 1'b1;
    checkOutput(0, "reset busy", d_busy[0], 1'b0);
    checkOutput(0, "reset w_valid", d_valid[0], 1'b0);
    checkOutput(0, "reset done", d_done[0], 1'b0);
    RST = 1'b1;

    abc_s = make_sched(ABC);
    checkOutput(0, "model W0", abc_s[0], 32'h61626380);
    checkOutput(0, "model W15", abc_s[15], 32'h00000018);
    checkOutput(0, "model W16", abc_s[16], 32'h61626380);
    checkOutput(0, "model W17", abc_s[17], 32'h000F0000);
    checkOutput(0, "model W18", abc_s[18], 32'h7DA86405);

    // "abc" block at full throughput
    @(negedge CLK);
    load_block(0, ABC);
    checkOutput(0, "t1 first valid", d_valid[0], 1'b1);
    checkOutput(0, "t1 W0", d_out[0], 32'h61626380);
    cnt = 0;
    for (int k = 0; k < 100 && d_valid[0] === 1'b1; k++) begin
      cnt++;
      if (d_idx[0] == 6'd15) checkOutput(0, "t1 W15", d_out[0], 32'h00000018);
      if (d_idx[0] == 6'd17) checkOutput(0, "t1 W17", d_out[0], 32'h000F0000);
      if (d_idx[0] == 6'd18) checkOutput(0, "t1 W18", d_out[0], 32'h7DA86405);
      @(negedge CLK);
    end
    checkOutput(0, "t1 valid count", cnt, 64);
    checkOutput(0, "t1 done pulse", d_done[0], 1'b1);
    checkOutput(0, "t1 busy in done", d_busy[0], 1'b1);
    @(negedge CLK);
    checkOutput(0, "t1 done cleared", d_done[0], 1'b0);
    checkOutput(0, "t1 busy fallen", d_busy[0], 1'b0);

    // backpressure while W[17] is presented
    load_block(0, ABC);
    wait_index(0, 17, 40);
    applyStimulus(0, 1'b0, ABC, 1'b0);
    repeat (5) begin
      @(negedge CLK);
      checkOutput(0, "t2 held w_out", d_out[0], 32'h000F0000);
      checkOutput(0, "t2 held w_index", d_idx[0], 32'd17);
    end
    applyStimulus(0, 1'b0, ABC, 1'b1);
    @(negedge CLK);
    checkOutput(0, "t2 next w_index", d_idx[0], 32'd18);
    checkOutput(0, "t2 next w_out", d_out[0], 32'h7DA86405);
    wait_idle(0, 100);

    // start with another block during RUN must be ignored
    for (int k = 0; k < 16; k++) other[k*32 +: 32] = $urandom();
    other_s = make_sched(other);
    load_block(0, ABC);
    wait_index(0, 10, 40);
    applyStimulus(0, 1'b1, other, 1'b1);
    repeat (3) @(negedge CLK);
    applyStimulus(0, 1'b0, other, 1'b1);
    wait_index(0, 63, 100);
    checkOutput(0, "t3 W63 unchanged", d_out[0], abc_s[63]);
    wait_idle(0, 100);
    load_block(0, other);
    checkOutput(0, "t3 new block valid", d_valid[0], 1'b1);
    checkOutput(0, "t3 new block W0", d_out[0], other_s[0]);
    wait_idle(0, 100);

    // reset in the middle of a stream
    load_block(0, ABC);
    wait_index(0, 30, 60);
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    checkOutput(0, "t4 w_valid", d_valid[0], 1'b0);
    checkOutput(0, "t4 busy", d_busy[0], 1'b0);
    checkOutput(0, "t4 done", d_done[0], 1'b0);
    checkOutput(0, "t4 w_out", d_out[0], 32'h0);
    checkOutput(0, "t4 w_index", d_idx[0], 32'h0);
    repeat (3) @(negedge CLK);
    checkOutput(0, "t4 no done", d_done[0], 1'b0);
    load_block(0, ABC);
    checkOutput(0, "t4 replay W0", d_out[0], 32'h61626380);
    wait_idle(0, 100);

    // 17-word instance
    load_block(1, ABC);
    cnt = 0;
    last_out = '0;
    for (int k = 0; k < 40 && d_valid[1] === 1'b1; k++) begin
      cnt++;
      last_out = d_out[1];
      @(negedge CLK);
    end
    checkOutput(1, "t5 valid count", cnt, 17);
    checkOutput(1, "t5 last word", last_out, 32'h61626380);
    checkOutput(1, "t5 done pulse", d_done[1], 1'b1);
    wait_idle(1, 10);

    // random blocks with random backpressure on both instances
    done_base[0] = dut_dones[0];
    done_base[1] = dut_dones[1];
    fork
      random_run(0, 250, 40000);
      random_run(1, 1000, 40000);
    join
    repeat (2) @(negedge CLK);
    checkOutput(0, "random done count", dut_dones[0] - done_base[0], 250);
    checkOutput(1, "random done count", dut_dones[1] - done_base[1], 1000);
    checkOutput(0, "total done count", dut_dones[0], m_dones[0]);
    checkOutput(1, "total done count", dut_dones[1], m_dones[1]);

    $display("[TB] scenarios complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
